// File: rtl/usbh_report_encoder_keypad.sv
// Re-encodes a 12-bit gamepad button vector into an 8-byte HID boot-keyboard
// report using keypad keycodes, scanned one button per cycle and offered on valid/ready.
module usbh_report_encoder_keypad #(
  parameter int unsigned IDLE_PERIOD    = 0,
  parameter int unsigned ROLLOVER_LIMIT = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_btn,
  output logic [63:0] o_report,
  output logic        o_report_valid,
  input  logic        i_report_ready
);

  localparam logic [23:0] IDLE_P = IDLE_PERIOD[23:0];
  localparam logic [2:0]  LIMIT  = ROLLOVER_LIMIT[2:0];

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_OFFER} state_t;

  state_t      state_q, state_d;
  logic [11:0] snap_q, snap_d;
  logic [11:0] last_q, last_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [47:0] work_q, work_d;
  logic [63:0] report_q, report_d;
  logic        valid_q, valid_d;
  logic [23:0] idle_q, idle_d;
  logic [63:0] rollover_report;
  logic        repeat_hit;

  function automatic logic [7:0] keycode(input logic [3:0] idx);
    case (idx)
      4'd0:    keycode = 8'h5F;
      4'd1:    keycode = 8'h59;
      4'd2:    keycode = 8'h57;
      4'd3:    keycode = 8'h58;
      4'd4:    keycode = 8'h60;
      4'd5:    keycode = 8'h5A;
      4'd6:    keycode = 8'h5C;
      4'd7:    keycode = 8'h5E;
      4'd8:    keycode = 8'h61;
      4'd9:    keycode = 8'h5B;
      4'd10:   keycode = 8'h62;
      4'd11:   keycode = 8'h63;
      default: keycode = 8'h00;
    endcase
  endfunction

  // ErrorRollOver fills exactly the usable slots; the rest stay zero.
  assign rollover_report[15:0] = 16'h0000;
  for (genvar gi = 0; gi < 6; gi++) begin : g_rollover
    assign rollover_report[16 + 8*gi +: 8] = (gi < int'(ROLLOVER_LIMIT)) ? 8'h01 : 8'h00;
  end

  assign repeat_hit = (IDLE_P != 24'd0) && (idle_q == IDLE_P - 24'd1);

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    last_d   = last_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    work_d   = work_q;
    report_d = report_q;
    valid_d  = valid_q;
    idle_d   = idle_q;
    case (state_q)
      S_IDLE: begin
        if ((i_btn != last_q) || repeat_hit) begin
          snap_d  = i_btn;
          idx_d   = 4'd0;
          cnt_d   = 3'd0;
          ovf_d   = 1'b0;
          work_d  = 48'd0;
          idle_d  = 24'd0;
          state_d = S_SCAN;
        end else begin
          idle_d = idle_q + 24'd1;
        end
      end
      S_SCAN: begin
        if (idx_q != 4'd12) begin
          idx_d = idx_q + 4'd1;
          if (snap_q[idx_q]) begin
            if (cnt_q < LIMIT) begin
              work_d[{cnt_q, 3'b000} +: 8] = keycode(idx_q);
              cnt_d = cnt_q + 3'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else begin
          report_d = ovf_q ? rollover_report : {work_q, 16'h0000};
          valid_d  = 1'b1;
          state_d  = S_OFFER;
        end
      end
      S_OFFER: begin
        // The button state is only committed as sent once the consumer takes it.
        if (i_report_ready) begin
          valid_d = 1'b0;
          last_d  = snap_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      snap_q   <= 12'd0;
      last_q   <= 12'd0;
      idx_q    <= 4'd0;
      cnt_q    <= 3'd0;
      ovf_q    <= 1'b0;
      work_q   <= 48'd0;
      report_q <= 64'd0;
      valid_q  <= 1'b0;
      idle_q   <= 24'd0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      work_q   <= work_d;
      report_q <= report_d;
      valid_q  <= valid_d;
      idle_q   <= idle_d;
    end
  end

  assign o_report       = report_q;
  assign o_report_valid = valid_q;

endmodule

// File: tb/tb_usbh_report_encoder_keypad.sv
// Bench for the keypad report encoder: two parameterisations share stimulus and are
// checked every cycle against a transaction-level model with a countdown for scan latency.
module tb_usbh_report_encoder_keypad;

  logic clk = 1'b0;
  logic rst;
  logic [11:0] btn;
  logic ready;
  logic [1:0][63:0] rep_w;
  logic [1:0] val_w;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] KMAP [12] = '{8'h5F, 8'h59, 8'h57, 8'h58, 8'h60, 8'h5A,
                                       8'h5C, 8'h5E, 8'h61, 8'h5B, 8'h62, 8'h63};

  always #5 clk = ~clk;

  usbh_report_encoder_keypad #(.IDLE_PERIOD(0), .ROLLOVER_LIMIT(6)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_btn(btn), .o_report(rep_w[0]),
    .o_report_valid(val_w[0]), .i_report_ready(ready));

  usbh_report_encoder_keypad #(.IDLE_PERIOD(50), .ROLLOVER_LIMIT(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_btn(btn), .o_report(rep_w[1]),
    .o_report_valid(val_w[1]), .i_report_ready(ready));

  function automatic int per_of(input int k);
    return (k == 0) ? 0 : 50;
  endfunction

  function automatic int lim_of(input int k);
    return (k == 0) ? 6 : 4;
  endfunction

  // Report from the list of pressed keycodes in button order.
  function automatic logic [63:0] expected(input logic [11:0] b, input int lim);
    logic [7:0] codes[$];
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 12; i++)
      if (b[i]) codes.push_back(KMAP[i]);
    if (codes.size() > lim) begin
      for (int s = 0; s < lim; s++) r[16 + 8*s +: 8] = 8'h01;
    end else begin
      for (int s = 0; s < codes.size(); s++) r[16 + 8*s +: 8] = codes[s];
    end
    return r;
  endfunction

  // Model: 0 idle, 1 waiting out the scan latency, 2 offering.
  logic [1:0][1:0]  m_st;
  logic [1:0][3:0]  m_wait;
  logic [1:0][31:0] m_cnt;
  logic [1:0][11:0] m_snap;
  logic [1:0][11:0] m_last;
  logic [1:0][63:0] m_rep;
  logic [1:0]       m_val;

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_st[k] <= 2'd0; m_wait[k] <= 4'd0; m_cnt[k] <= 32'd0; m_snap[k] <= 12'd0;
        m_last[k] <= 12'd0; m_rep[k] <= 64'd0; m_val[k] <= 1'b0;
      end else begin
        case (m_st[k])
          2'd0: begin
            if ((btn != m_last[k]) || (per_of(k) != 0 && m_cnt[k] == 32'(per_of(k) - 1))) begin
              m_snap[k] <= btn; m_wait[k] <= 4'd13; m_st[k] <= 2'd1; m_cnt[k] <= 32'd0;
            end else begin
              m_cnt[k] <= m_cnt[k] + 32'd1;
            end
          end
          2'd1: begin
            if (m_wait[k] == 4'd1) begin
              m_rep[k] <= expected(m_snap[k], lim_of(k)); m_val[k] <= 1'b1; m_st[k] <= 2'd2;
            end else begin
              m_wait[k] <= m_wait[k] - 4'd1;
            end
          end
          default: begin
            if (ready) begin
              m_val[k] <= 1'b0; m_last[k] <= m_snap[k]; m_st[k] <= 2'd0;
            end
          end
        endcase
      end
    end
  end

  // Single per-cycle compare process, sampled on the inactive edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_w[k] !== m_val[k]) begin
        errors++;
        $display("FAIL cyc_valid%0d @%0t: got %b expected %b", k, $time, val_w[k], m_val[k]);
      end
      checks++;
      if (rep_w[k] !== m_rep[k]) begin
        errors++;
        $display("FAIL cyc_report%0d @%0t: got %h expected %h", k, $time, rep_w[k], m_rep[k]);
      end
      if (val_w[k] && ready && !rst)
        $display("xfer dut%0d @%0t report %h", k, $time, rep_w[k]);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; btn = 12'd0; ready = 1'b1;
    chk("model_b",      expected(12'h001, 6), 64'h0000_0000_005F_0000);
    chk("model_dpad",   expected(12'h0F0, 6), 64'h0000_5E5C_5A60_0000);
    chk("model_roll6",  expected(12'h7F0, 6), 64'h0101_0101_0101_0000);
    chk("model_roll4",  expected(12'h1F0, 4), 64'h0000_0101_0101_0000);
    chk("model_ac",     expected(12'h00C, 6), 64'h0000_0000_5857_0000);
    step(3);
    chk("reset_valid", {63'd0, val_w[0]}, 64'd0);
    chk("reset_report", rep_w[0], 64'd0);
    rst = 1'b0;

    step(100);
    chk("idle_valid", {63'd0, val_w[0]}, 64'd0);
    chk("idle_report", rep_w[0], 64'd0);

    btn = 12'h001;
    step(13);
    chk("b_latency_low", {63'd0, val_w[0]}, 64'd0);
    step(1);
    chk("b_valid", {63'd0, val_w[0]}, 64'd1);
    chk("b_report", rep_w[0], 64'h0000_0000_005F_0000);
    step(1);
    chk("b_done", {63'd0, val_w[0]}, 64'd0);
    chk("b_held", rep_w[0], 64'h0000_0000_005F_0000);

    step(20);
    ready = 1'b0; btn = 12'h0F0;
    step(14);
    chk("dpad_report", rep_w[0], 64'h0000_5E5C_5A60_0000);
    step(5);
    btn = 12'h001;
    step(15);
    chk("dpad_stall_valid", {63'd0, val_w[0]}, 64'd1);
    chk("dpad_stall_report", rep_w[0], 64'h0000_5E5C_5A60_0000);
    ready = 1'b1;
    step(1);
    chk("dpad_done", {63'd0, val_w[0]}, 64'd0);
    step(14);
    chk("coalesced_valid", {63'd0, val_w[0]}, 64'd1);
    chk("coalesced_report", rep_w[0], 64'h0000_0000_005F_0000);

    step(5);
    btn = 12'h7F0;
    step(14);
    chk("roll_report", rep_w[0], 64'h0101_0101_0101_0000);
    step(1);
    btn = 12'h000;
    step(14);
    chk("release_valid", {63'd0, val_w[0]}, 64'd1);
    chk("release_report", rep_w[0], 64'd0);

    btn = 12'h800;
    step(100);
    for (int i = 0; i < 200 && !val_w[1]; i++) step(1);
    chk("repeat_seen", {63'd0, val_w[1]}, 64'd1);
    step(63);
    chk("repeat_gap", {63'd0, val_w[1]}, 64'd0);
    step(1);
    chk("repeat_valid", {63'd0, val_w[1]}, 64'd1);
    chk("repeat_report", rep_w[1], 64'h0000_0000_0063_0000);

    step(5);
    ready = 1'b0; btn = 12'h00C;
    step(5);
    #1 rst = 1'b1;
    #1 chk("rst_scan_valid", {63'd0, val_w[0]}, 64'd0);
    step(1);
    rst = 1'b0;
    step(14);
    chk("post_rst_valid", {63'd0, val_w[0]}, 64'd1);
    chk("post_rst_report", rep_w[0], 64'h0000_0000_5857_0000);
    step(3);
    rst = 1'b1;
    #1 chk("rst_offer_valid", {63'd0, val_w[0]}, 64'd0);
    chk("rst_offer_report", rep_w[0], 64'd0);
    step(1);
    rst = 1'b0; ready = 1'b1;
    step(14);
    chk("redetect_valid", {63'd0, val_w[0]}, 64'd1);
    chk("redetect_report", rep_w[0], 64'h0000_0000_5857_0000);
    step(1);
    chk("redetect_done", {63'd0, val_w[0]}, 64'd0);

    step(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usbh_report_encoder_keypad.md
Name: usbh_report_encoder_keypad

Overview:
- Converts the 12-bit gamepad button vector back into an 8-byte HID boot-keyboard report using keypad keycodes. This is the inverse of the keypad report decoder.
- Drives device-side USB emulation and loopback self-test of the host decoder path.
- Emits a report only when the button state changes, or on an optional idle-repeat timer.
- Keycodes are placed by a sequential 12-step scan, and results are offered over a valid/ready handshake.

Parameters:
IDLE_PERIOD, 0, cycles spent in IDLE with unchanged buttons before the current report is re-sent; 0 disables repeat; 24-bit range.
ROLLOVER_LIMIT, 6, maximum keycode slots; more pressed buttons than this produce an ErrorRollOver report; legal values 1..6.

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset, asynchronous assert, active-high
i_btn  input  12  button state, synchronous to i_clk; order {r,l,x,a,right,left,down,up,start,select,y,b} (bit 0 = b)
o_report  output  64  HID report: [7:0] modifier, [15:8] reserved, [23:16]..[63:56] keycodes 0..5
o_report_valid  output  1  report offered
i_report_ready  input  1  consumer accepts; transfer happens on a rising edge where valid&&ready

Behaviour:
- Reset values while i_rst is high: o_report=0, o_report_valid=0, last_sent=0, idle counter=0, state=IDLE.
  - Reset is asynchronous and may arrive mid-scan or mid-offer: valid drops immediately, and any pending report is discarded.
- Keycode map by bit index 0..11: 0x5F, 0x59, 0x57, 0x58, 0x60, 0x5A, 0x5C, 0x5E, 0x61, 0x5B, 0x62, 0x63.
- Modifier byte and reserved byte are always 0x00. Unused keycode slots are 0x00.
- FSM states: IDLE, SCAN, OFFER.
- IDLE:
  - Idle counter increments each cycle.
  - Trigger condition: (i_btn != last_sent), or (IDLE_PERIOD != 0 and counter == IDLE_PERIOD-1).
  - On trigger at edge E: snapshot<=i_btn, scan index<=0, slot count<=0, working report<=0, state<=SCAN, counter<=0.
  - A change takes priority over repeat; both use the same path.
- SCAN, edges E+1..E+12, one bit per edge, index 0..11 ascending:
  - If the snapshot bit is set and count<ROLLOVER_LIMIT: write its keycode into slot[count], count++.
  - If the bit is set and count==ROLLOVER_LIMIT: set the overflow flag.
- Report load at edge E+13:
  - o_report<=working report, o_report_valid<=1, state<=OFFER.
  - If overflow: every slot up to ROLLOVER_LIMIT =0x01 (ErrorRollOver), remaining slots 0x00, modifier 0.
- Fixed latency: detection edge to valid-high is 13 cycles.
- OFFER:
  - o_report is held stable while valid is high.
  - On an edge with i_report_ready=1: o_report_valid<=0, last_sent<=snapshot, state<=IDLE.
  - Ready asserted combinationally in the first OFFER cycle is legal; the transfer completes at that edge.
  - o_report keeps its last value after the transfer.
- i_btn changes during SCAN or OFFER are ignored and coalesced. They are re-evaluated in the first IDLE cycle after the handshake, so the minimum report-to-report spacing is 15 cycles.
- Release of all buttons is a change and yields an all-zero report.
- Back-pressure: the FSM stays in OFFER indefinitely. The idle counter does not run outside IDLE.
- last_sent is updated only on handshake. A report discarded by reset is never counted as sent.

Test Plan:
- Reset, then i_btn=0 held 100 cycles, IDLE_PERIOD=0 -> o_report_valid never asserts; o_report=0.
- i_btn=0x001 (b) at detection edge E, ready=1 -> valid high at E+13; o_report=0x0000_0000_005F_0000; a single transfer, then idle.
- i_btn=0x0F0 (up,down,left,right), ready=0 for 20 cycles, then 1 -> o_report=0x0000_5E5C_5A60_0000 stable throughout; i_btn toggled to 0x001 during the wait -> the next report, 15 cycles after the handshake, carries only 0x5F.
- i_btn=0x7F0 (7 pressed), ROLLOVER_LIMIT=6 -> o_report=0x0101_0101_0101_0000; then i_btn=0 -> report 0x0.
- IDLE_PERIOD=50, i_btn held 0x800 (r) after the first transfer -> an identical report (0x63 in slot 0) is re-offered every 64 cycles (50 idle + 13 scan/load + 1 handshake, ready=1).
- Assert i_rst asynchronously during SCAN and again during OFFER -> valid drops immediately; after release, the held i_btn is re-detected and a full report is produced 13 cycles after detection.
